// File: rtl/pipeline_if_if.sv
// Instruction-memory port of the fetch stage: the stage drives the address,
// the memory answers with a word and a ready strobe in the same cycle.
interface pipeline_if_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        imem_ready;

    modport master (
        output imem_addr,
        input  imem_data,
        input  imem_ready
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output imem_ready
    );
endinterface

// File: rtl/pipeline_if.sv
// MIPS instruction-fetch stage: PC register, imem handshake and IF/ID register.
// Decode redirects cost one bubble; a hazard stall freezes PC and IF/ID.
module pipeline_if #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] ILLOP_PC = 32'h8000_0004,
    parameter logic [31:0] XADR_PC  = 32'h8000_0008,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [2:0]       PCSrc,
    input  logic             Branch,
    input  logic             IDcontrol_Branch,
    input  logic             IDcontrol_Jump,
    input  logic [31:0]      ConBA,
    input  logic [25:0]      JT,
    input  logic [31:0]      PCout,
    pipeline_if_if.master    imem,
    output logic [31:0]      ID_PC,
    output logic [31:0]      ID_instruction,
    output logic [CNT_W-1:0] fetch_count
);

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      id_pc_q, id_pc_d;
    logic [31:0]      id_instr_q, id_instr_d;
    logic [CNT_W-1:0] fetch_count_q, fetch_count_d;
    logic [31:0]      pc_plus4;
    logic             exc, jmp, br, redirect;

    // Sequential increment never touches the supervisor bit.
    always_comb begin
        pc_plus4 = {pc_q[31], pc_q[30:0] + 31'd4};
        exc      = (PCSrc == 3'd4) || (PCSrc == 3'd5);
        jmp      = IDcontrol_Jump && ((PCSrc == 3'd2) || (PCSrc == 3'd3));
        br       = Branch && IDcontrol_Branch && (PCSrc == 3'd1);
        redirect = !stall && (exc || jmp || br);
    end

    always_comb begin
        pc_d          = pc_q;
        id_pc_d       = id_pc_q;
        id_instr_d    = id_instr_q;
        fetch_count_d = fetch_count_q;
        if (!stall) begin
            id_pc_d    = pc_plus4;
            id_instr_d = 32'h0;
            if (redirect) begin
                if (PCSrc == 3'd4) begin
                    pc_d = ILLOP_PC;
                end else if (PCSrc == 3'd5) begin
                    pc_d = XADR_PC;
                end else if (jmp && (PCSrc == 3'd2)) begin
                    pc_d = {id_pc_q[31:28], JT, 2'b00};
                end else if (jmp) begin
                    pc_d = PCout;
                end else begin
                    pc_d = ConBA;
                end
            end else if (imem.imem_ready) begin
                pc_d          = pc_plus4;
                id_instr_d    = imem.imem_data;
                fetch_count_d = fetch_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q          <= RESET_PC;
            id_pc_q       <= RESET_PC;
            id_instr_q    <= 32'h0;
            fetch_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            id_pc_q       <= id_pc_d;
            id_instr_q    <= id_instr_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem.imem_addr = pc_q;
    assign ID_PC          = id_pc_q;
    assign ID_instruction = id_instr_q;
    assign fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_pipeline_if.sv
// Directed bench for pipeline_if: a cycle model of the fetch rules is checked
// every cycle, plus literal expectations at key points of the program.
module tb_pipeline_if;

    localparam logic [31:0] MEM_KEY = 32'h1357_9BDF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic [2:0]  pc_src;
    logic        branch, id_branch, id_jump;
    logic [31:0] con_ba, pc_out;
    logic [25:0] jt;
    logic        ready;
    logic        nop_mode;

    logic [31:0] id_pc, id_instr, fetch_count;
    logic [31:0] id_pc2, id_instr2;
    logic [2:0]  fetch_count2;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [31:0] m_pc, m_id_pc, m_instr, m_cnt;
    logic [31:0] m_seq, m_target;
    logic        m_taken;
    logic        m_valid = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr, input logic nop);
        return nop ? 32'h0 : (addr ^ MEM_KEY);
    endfunction

    pipeline_if_if bus ();
    pipeline_if_if bus2 ();

    assign bus.imem_data   = mem_word(bus.imem_addr, nop_mode);
    assign bus.imem_ready  = ready;
    assign bus2.imem_data  = mem_word(bus2.imem_addr, nop_mode);
    assign bus2.imem_ready = ready;

    pipeline_if dut (
        .clk(clk), .reset(rst_n), .stall(stall), .PCSrc(pc_src),
        .Branch(branch), .IDcontrol_Branch(id_branch), .IDcontrol_Jump(id_jump),
        .ConBA(con_ba), .JT(jt), .PCout(pc_out), .imem(bus),
        .ID_PC(id_pc), .ID_instruction(id_instr), .fetch_count(fetch_count)
    );

    // Narrow counter instance so the wrap-around is reachable in a short run.
    pipeline_if #(.CNT_W(3)) dut_w (
        .clk(clk), .reset(rst_n), .stall(stall), .PCSrc(pc_src),
        .Branch(branch), .IDcontrol_Branch(id_branch), .IDcontrol_Jump(id_jump),
        .ConBA(con_ba), .JT(jt), .PCout(pc_out), .imem(bus2),
        .ID_PC(id_pc2), .ID_instruction(id_instr2), .fetch_count(fetch_count2)
    );

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: what the stage must hold after each edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_pc    = 32'h8000_0000;
            m_id_pc = 32'h8000_0000;
            m_instr = 32'h0;
            m_cnt   = 32'h0;
            m_valid = 1'b1;
        end else if (m_valid && !stall) begin
            m_seq    = {m_pc[31], m_pc[30:0] + 31'd4};
            m_taken  = 1'b1;
            m_target = 32'h0;
            case (pc_src)
                3'd4: m_target = 32'h8000_0004;
                3'd5: m_target = 32'h8000_0008;
                3'd2: if (id_jump) m_target = {m_id_pc[31:28], jt, 2'b00}; else m_taken = 1'b0;
                3'd3: if (id_jump) m_target = pc_out; else m_taken = 1'b0;
                3'd1: if (branch && id_branch) m_target = con_ba; else m_taken = 1'b0;
                default: m_taken = 1'b0;
            endcase
            m_id_pc = m_seq;
            if (m_taken) begin
                m_pc    = m_target;
                m_instr = 32'h0;
            end else if (ready) begin
                m_instr = mem_word(m_pc, nop_mode);
                m_pc    = m_seq;
                m_cnt   = m_cnt + 32'd1;
            end else begin
                m_instr = 32'h0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (m_valid) begin
            check_output("model imem_addr", bus.imem_addr, m_pc);
            check_output("model ID_PC", id_pc, m_id_pc);
            check_output("model ID_instruction", id_instr, m_instr);
            check_output("model fetch_count", fetch_count, m_cnt);
            check_output("model fetch_count w3", {29'b0, fetch_count2}, {29'b0, m_cnt[2:0]});
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0; stall = 1'b0; pc_src = 3'd0; branch = 1'b0; id_branch = 1'b0;
        id_jump = 1'b0; con_ba = 32'h0; pc_out = 32'h0; jt = 26'h0; ready = 1'b0; nop_mode = 1'b0;
        tick(2);
        check_output("reset imem_addr", bus.imem_addr, 32'h8000_0000);
        check_output("reset ID_PC", id_pc, 32'h8000_0000);
        check_output("reset ID_instruction", id_instr, 32'h0);
        check_output("reset fetch_count", fetch_count, 32'h0);

        rst_n = 1'b1; ready = 1'b1;
        tick(1);
        check_output("first ID_PC", id_pc, 32'h8000_0004);
        check_output("first ID_instruction", id_instr, 32'h9357_9BDF);
        check_output("first imem_addr", bus.imem_addr, 32'h8000_0004);
        tick(2);
        check_output("three fetches count", fetch_count, 32'd3);
        check_output("three fetches addr", bus.imem_addr, 32'h8000_000C);

        branch = 1'b1; id_branch = 1'b1; pc_src = 3'd1; con_ba = 32'h0040_0020;
        tick(1);
        check_output("beq taken addr", bus.imem_addr, 32'h0040_0020);
        check_output("beq taken bubble", id_instr, 32'h0);
        check_output("beq taken count", fetch_count, 32'd3);
        branch = 1'b0; id_branch = 1'b0; pc_src = 3'd0;
        tick(1);

        branch = 1'b1; id_branch = 1'b0; pc_src = 3'd1;
        tick(1);
        check_output("beq not taken addr", bus.imem_addr, 32'h0040_0028);
        check_output("beq not taken instr", id_instr, 32'h1317_9BFB);

        branch = 1'b0; pc_src = 3'd2; id_jump = 1'b1; jt = 26'h010_0040;
        tick(1);
        check_output("j target", bus.imem_addr, 32'h0040_0100);
        check_output("j bubble", id_instr, 32'h0);

        pc_src = 3'd4; id_jump = 1'b0; rst_n = 1'b0;
        tick(1);
        check_output("midreset imem_addr", bus.imem_addr, 32'h8000_0000);
        check_output("midreset ID_instruction", id_instr, 32'h0);
        check_output("midreset fetch_count", fetch_count, 32'h0);
        check_output("midreset ID_PC", id_pc, 32'h8000_0000);
        rst_n = 1'b1; pc_src = 3'd0;
        tick(2);

        id_jump = 1'b1; pc_src = 3'd3; pc_out = 32'h8000_0100;
        tick(1);
        pc_out = 32'h0000_1234;
        tick(1);
        check_output("jr user addr", bus.imem_addr, 32'h0000_1234);
        check_output("jr ID_PC", id_pc, 32'h8000_0104);
        id_jump = 1'b0; pc_src = 3'd0;
        tick(1);

        stall = 1'b1; branch = 1'b1; id_branch = 1'b1; pc_src = 3'd1; con_ba = 32'h0040_0040;
        tick(2);
        check_output("stall addr", bus.imem_addr, 32'h0000_1238);
        check_output("stall ID_PC", id_pc, 32'h0000_1238);
        check_output("stall ID_instruction", id_instr, 32'h1357_89EB);
        check_output("stall fetch_count", fetch_count, 32'd3);
        stall = 1'b0;
        tick(1);
        check_output("post-stall branch addr", bus.imem_addr, 32'h0040_0040);
        branch = 1'b0; id_branch = 1'b0; pc_src = 3'd0; ready = 1'b0;
        tick(3);
        check_output("wait addr", bus.imem_addr, 32'h0040_0040);
        check_output("wait count", fetch_count, 32'd3);
        check_output("wait bubble", id_instr, 32'h0);
        pc_src = 3'd4;
        tick(1);
        check_output("illop during wait", bus.imem_addr, 32'h8000_0004);
        pc_src = 3'd0; stall = 1'b1;
        tick(1);
        stall = 1'b0; ready = 1'b1; pc_src = 3'd5;
        tick(1);
        check_output("xadr addr", bus.imem_addr, 32'h8000_0008);
        pc_src = 3'd6;
        tick(1);
        pc_src = 3'd7;
        tick(1);
        check_output("pcsrc 6/7 addr", bus.imem_addr, 32'h8000_0010);
        check_output("pcsrc 6/7 count", fetch_count, 32'd5);

        pc_src = 3'd0; nop_mode = 1'b1;
        tick(1);
        check_output("nop count", fetch_count, 32'd6);
        check_output("nop instr", id_instr, 32'h0);
        nop_mode = 1'b0;

        id_jump = 1'b1; pc_src = 3'd3; pc_out = 32'hFFFF_FFFC;
        tick(1);
        id_jump = 1'b0; pc_src = 3'd0;
        tick(1);
        check_output("bit31 kept addr", bus.imem_addr, 32'h8000_0000);
        check_output("bit31 kept ID_PC", id_pc, 32'h8000_0000);
        id_jump = 1'b1; pc_src = 3'd3; pc_out = 32'h7FFF_FFFC;
        tick(1);
        id_jump = 1'b0; pc_src = 3'd0;
        tick(1);
        check_output("user wrap addr", bus.imem_addr, 32'h0000_0000);

        tick(12);
        check_output("final count", fetch_count, 32'd20);
        check_output("final count w3", {29'b0, fetch_count2}, 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/pipeline_if.md
Name: pipeline_if

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the PC register, the instruction-memory address and ready handshake, and the IF/ID pipeline register that produces ID_PC and ID_instruction for the decode stage. Consumes the decode stage's redirect outputs (PCSrc, ConBA, JT, PCout, IDcontrol_Jump, IDcontrol_Branch, Branch) and the hazard unit's stall request. Performs PC selection, flush (bubble insertion) and stall hold.

Parameters:
RESET_PC, 32'h8000_0000, PC after reset (kernel mode, bit31=1)
ILLOP_PC, 32'h8000_0004, interrupt/illegal-op vector (PCSrc=4)
XADR_PC, 32'h8000_0008, exception vector (PCSrc=5)
CNT_W, 32, width of fetched-instruction counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
stall  in  1  load-use hold from hazard unit
PCSrc  in  3  PC source from decode control
Branch  in  1  ID instruction is a conditional branch
IDcontrol_Branch  in  1  ID branch condition true
IDcontrol_Jump  in  1  ID instruction is j/jal/jr/jalr
ConBA  in  32  branch target (ID_PC + sext-free imm<<2)
JT  in  26  jump field
PCout  in  32  jr/jalr register target
imem_data  in  32  instruction word at imem_addr
imem_ready  in  1  imem_data valid this cycle
imem_addr  out  32  current PC
ID_PC  out  32  PC+4 of instruction in ID
ID_instruction  out  32  instruction in ID (0 = bubble)
fetch_count  out  CNT_W  non-bubble instructions delivered to ID

Behaviour:
- Reset (reset==0 at rising edge): PC<=RESET_PC; ID_PC<=RESET_PC; ID_instruction<=0; fetch_count<=0. Applies mid-operation and overrides every other input.
- imem_addr = PC, combinational. PC_plus4 = {PC[31], PC[30:0]+4}; bit31 (supervisor) never changes through sequential increment.
- Redirect evaluation is gated by !stall:
  - exc = PCSrc==4 or PCSrc==5
  - jmp = IDcontrol_Jump and PCSrc in {2,3}
  - br = Branch and IDcontrol_Branch and PCSrc==1
  - redirect = !stall and (exc or jmp or br)
- Next-PC priority:
  1. stall: PC holds.
  2. PCSrc==4: ILLOP_PC.
  3. PCSrc==5: XADR_PC.
  4. jmp, PCSrc==2: {ID_PC[31:28], JT, 2'b00}.
  5. jmp, PCSrc==3: PCout (full 32 bits, so bit31 may drop for return to user mode).
  6. br: ConBA.
  7. imem_ready: PC_plus4.
  8. Otherwise PC holds (memory wait).
  - PCSrc==1 with the condition false is not a redirect; fall to case 7 or 8.
  - PCSrc values 6 and 7 are treated as 0.
- IF/ID register:
  - stall: ID_PC and ID_instruction hold; fetch_count holds.
  - else if redirect: ID_instruction<=0 (flush), ID_PC<=PC_plus4, fetch_count holds.
  - else if imem_ready: ID_instruction<=imem_data, ID_PC<=PC_plus4, fetch_count<=fetch_count+1 (wraps modulo 2^CNT_W).
  - else (wait): ID_instruction<=0, ID_PC<=PC_plus4, count holds.
- A fetched word of 32'h0 (nop) still increments fetch_count.
- Redirect during imem wait: the outstanding fetch is abandoned, PC takes the target, and ID receives a bubble.
- Stall with imem_ready==0: stall dominates, and everything holds.
- Latency: instruction at PC appears on ID_instruction one clock after imem_ready is sampled high. Branch and jump penalty is exactly one bubble.
- No combinational path from imem_data to imem_addr.

Test Plan:
- Reset then imem_ready=1, straight-line code: PC sequence 8000_0000, 8000_0004, 8000_0008. ID_PC=8000_0004 when the first instruction reaches ID. fetch_count=3 after 3 fetches.
- Taken beq in ID (Branch=1, IDcontrol_Branch=1, PCSrc=1, ConBA=0040_0020): next PC=0040_0020 and ID_instruction=0 for one cycle. The same stimulus with IDcontrol_Branch=0 gives PC+4 and no bubble.
- j with ID_PC=0040_0010, JT=26'h010_0040: PC=0040_0100. jr with PCOut=0000_1234 from PC 8000_0100: PC=0000_1234 (bit31 cleared).
- stall=1 for 2 cycles while ID holds beq with PCSrc=1 and IDcontrol_Branch=1: PC, ID_PC, ID_instruction and fetch_count unchanged. Redirect occurs on the first cycle with stall=0.
- imem_ready=0 for 3 cycles: PC holds, three bubbles enter ID, fetch_count unchanged. PCSrc=4 asserted during the wait: PC=8000_0004 next cycle.
- reset asserted low mid-stream with PC=0040_0100: after the edge PC=8000_0000, ID_instruction=0, fetch_count=0. Force fetch_count=FFFF_FFFF with CNT_W=32: next fetch wraps it to 0.
